// File: rtl/toggle_hs_rx_pkg.sv
// toggle_hs_pkg: shared types and constants for the toggle handshake receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state encoding, synchronizer depth limits, default word width.
package toggle_hs_pkg;

  // Limits on the req_tgl synchronizer depth.
  localparam int SYNC_MIN   = 2;
  localparam int SYNC_MAX   = 4;

  // Default transferred word width.
  localparam int DEF_DATA_W = 8;

  // Receiver FSM: IDLE waits for a request edge, VALID holds a word for the consumer.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    VALID = 1'b1
  } state_e;

endpackage

// File: rtl/toggle_hs_rx_if.sv
// toggle_hs_rx_if: bundles the sender-side toggle handshake and the consumer-side valid/ready bus.
// Latency: n/a (wires only).
// Backpressure: out_ready from the consumer; the sender is throttled by ack_tgl.
// Ports (slave = receiver view):
//   in : req_tgl, data_in, out_ready, clr_overrun [, data_par]
//   out: out_valid, out_data, ack_tgl, busy, overrun [, par_err]
// Optional parity signals exist only when TOGGLE_HS_RX_PARITY_EN is defined.
interface toggle_hs_rx_if
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req_tgl;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              ack_tgl;
  logic              busy;
  logic              overrun;
  logic              clr_overrun;
`ifdef TOGGLE_HS_RX_PARITY_EN
  logic              data_par;
  logic              par_err;
`endif

  // Environment side: sender plus consumer.
  modport master (
    output req_tgl, data_in, out_ready, clr_overrun,
`ifdef TOGGLE_HS_RX_PARITY_EN
    output data_par,
    input  par_err,
`endif
    input  out_valid, out_data, ack_tgl, busy, overrun
  );

  // Receiver side.
  modport slave (
    input  req_tgl, data_in, out_ready, clr_overrun,
`ifdef TOGGLE_HS_RX_PARITY_EN
    input  data_par,
    output par_err,
`endif
    output out_valid, out_data, ack_tgl, busy, overrun
  );

endinterface

// File: rtl/toggle_hs_rx_sync.sv
// toggle_sync: brings the asynchronous req_tgl into clk and flags each level change.
// Latency: req_edge is high SYNC_STAGES cycles after req_tgl changes, for exactly one cycle.
// Backpressure: none; every change of the synchronized level yields one edge pulse.
// Ports: clk, rst (sync, active-low), req_tgl (async in), req_edge (out).
module toggle_sync
  import toggle_hs_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic req_tgl,
  output logic req_edge
);

  if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_stages
    $error("toggle_sync: SYNC_STAGES out of range");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_prev_q, req_prev_d;
  logic                   sync_out;

  always_comb begin
    // sync_q[0] is the metastability-catching flop; the top bit is the safe output.
    sync_d     = {sync_q[SYNC_STAGES-2:0], req_tgl};
    sync_out   = sync_q[SYNC_STAGES-1];
    req_prev_d = sync_out;
    req_edge   = sync_out ^ req_prev_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q     <= '0;
      req_prev_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      req_prev_q <= req_prev_d;
    end
  end

endmodule

// File: rtl/toggle_hs_rx.sv
// toggle_hs_rx: receiving end of a two-phase req/ack handshake, presenting words on valid/ready.
// Latency: req_tgl toggle to out_valid is SYNC_STAGES+1 clk cycles; ack_tgl toggles one cycle after acceptance.
// Backpressure: out_ready low holds the word; a request arriving meanwhile is dropped and flagged in overrun.
// Ports: clk, rst (sync, active-low), hs (toggle_hs_rx_if.slave).
// Optional: define TOGGLE_HS_RX_PARITY_EN to add data_par / sticky par_err (even parity over data_in+data_par).
module toggle_hs_rx
  import toggle_hs_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  toggle_hs_rx_if.slave  hs
);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_VALID = VALID;

  logic              req_edge;
  logic [0:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              ack_tgl_q, ack_tgl_d;
  logic              overrun_q, overrun_d;
  logic              capture;
  logic              overrun_set;

  toggle_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .req_tgl  (hs.req_tgl),
    .req_edge (req_edge)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ack_tgl_d   = ack_tgl_q;
    capture     = 1'b0;
    overrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_edge) begin
          capture     = 1'b1;
          out_valid_d = 1'b1;
          state_d     = ST_VALID;
        end
      end
      ST_VALID: begin
        if (hs.out_ready) begin
          // Acceptance acknowledges the held word; the sender may already
          // have a new one on the way, which then replaces it seamlessly.
          ack_tgl_d = ~ack_tgl_q;
          if (req_edge) begin
            capture = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (req_edge) begin
          // Nowhere to put the new word: keep the old one, drop the edge.
          overrun_set = 1'b1;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase

    if (capture) begin
      out_data_d = hs.data_in;
    end

    // Set wins over clear so an overrun coinciding with a clear is not lost.
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (hs.clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ack_tgl_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ack_tgl_q   <= ack_tgl_d;
      overrun_q   <= overrun_d;
    end
  end

  assign hs.out_valid = out_valid_q;
  assign hs.out_data  = out_data_q;
  assign hs.ack_tgl   = ack_tgl_q;
  assign hs.busy      = (state_q == ST_VALID);
  assign hs.overrun   = overrun_q;

`ifdef TOGGLE_HS_RX_PARITY_EN
  logic par_err_q, par_err_d;

  always_comb begin
    // Even parity: data_in plus data_par must XOR to zero.
    if (capture && (^{hs.data_in, hs.data_par})) begin
      par_err_d = 1'b1;
    end else if (hs.clr_overrun) begin
      par_err_d = 1'b0;
    end else begin
      par_err_d = par_err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign hs.par_err = par_err_q;
`endif

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb_toggle_hs_rx: self-checking bench for toggle_hs_rx.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_toggle_hs_rx;
  import toggle_hs_pkg::*;

  localparam int DW  = DEF_DATA_W;
  localparam int SS  = 2;
  localparam int LAT = SS + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  toggle_hs_rx_if #(.DATA_W(DW)) hs ();

  toggle_hs_rx #(
    .DATA_W      (DW),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hs  (hs)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sender: present a word with correct parity and toggle the request.
  task automatic send(input logic [7:0] d);
    hs.data_in = d;
`ifdef TOGGLE_HS_RX_PARITY_EN
    hs.data_par = ^d;
`endif
    hs.req_tgl = ~hs.req_tgl;
  endtask

  typedef struct {
    logic [7:0] data;
    int         stall;
    logic [7:0] exp_data;
    logic       exp_ack;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ack_exp;
    logic        ack_obs;
    logic [7:0]  expq[$];
    int          idx, got, gap, cyc, toggles;
    logic        waiting, acc;

    tbl[0] = '{8'hA5, 0,  8'hA5, 1'b1};
    tbl[1] = '{8'h3C, 10, 8'h3C, 1'b0};
    tbl[2] = '{8'hFF, 1,  8'hFF, 1'b1};
    tbl[3] = '{8'h00, 3,  8'h00, 1'b0};

    hs.req_tgl     = 1'b0;
    hs.data_in     = '0;
    hs.out_ready   = 1'b0;
    hs.clr_overrun = 1'b0;
`ifdef TOGGLE_HS_RX_PARITY_EN
    hs.data_par    = 1'b0;
`endif

    // ---- reset ----
    rst = 1'b0;
    tick(3);
    chk("rst_valid",   hs.out_valid, 0);
    chk("rst_data",    hs.out_data,  0);
    chk("rst_ack",     hs.ack_tgl,   0);
    chk("rst_busy",    hs.busy,      0);
    chk("rst_overrun", hs.overrun,   0);
`ifdef TOGGLE_HS_RX_PARITY_EN
    chk("rst_par_err", hs.par_err,   0);
`endif
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", hs.out_valid, 0);
    end

    // ---- table: single transfers with varying back-pressure ----
    ack_exp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      hs.out_ready = 1'b0;
      send(tbl[i].data);
      tick(LAT - 1);
      chk("lat_early_valid", hs.out_valid, 0);
      tick();
      chk("lat_valid", hs.out_valid, 1);
      chk("lat_data",  hs.out_data,  tbl[i].exp_data);
      chk("lat_busy",  hs.busy,      1);
      for (int s = 0; s < tbl[i].stall; s++) begin
        tick();
        chk("stall_valid", hs.out_valid, 1);
        chk("stall_data",  hs.out_data,  tbl[i].exp_data);
        chk("stall_busy",  hs.busy,      1);
        chk("stall_ack",   hs.ack_tgl,   ack_exp);
      end
      hs.out_ready = 1'b1;
      tick();
      hs.out_ready = 1'b0;
      chk("acc_ack",   hs.ack_tgl,   tbl[i].exp_ack);
      chk("acc_valid", hs.out_valid, 0);
      chk("acc_busy",  hs.busy,      0);
      chk("hold_data", hs.out_data,  tbl[i].exp_data);
      ack_exp = tbl[i].exp_ack;
      tick(2);
      chk("no_extra_ack", hs.ack_tgl, ack_exp);
    end

    // ---- overrun and clear ----
    send(8'h11);
    tick(LAT);
    chk("ovr_first_data", hs.out_data, 8'h11);
    send(8'h22);
    tick(LAT + 1);
    chk("ovr_set",        hs.overrun,   1);
    chk("ovr_keep_data",  hs.out_data,  8'h11);
    chk("ovr_keep_valid", hs.out_valid, 1);
    hs.clr_overrun = 1'b1;
    tick();
    hs.clr_overrun = 1'b0;
    chk("ovr_clr", hs.overrun, 0);
    send(8'h33);
    tick(LAT - 1);
    hs.clr_overrun = 1'b1;
    tick();
    hs.clr_overrun = 1'b0;
    chk("ovr_set_beats_clr", hs.overrun,  1);
    chk("ovr_keep_data2",    hs.out_data, 8'h11);
    hs.out_ready = 1'b1;
    tick();
    hs.out_ready = 1'b0;
    ack_exp = ~ack_exp;
    chk("ovr_acc_ack",   hs.ack_tgl,   ack_exp);
    chk("ovr_acc_valid", hs.out_valid, 0);
    chk("ovr_acc_data",  hs.out_data,  8'h11);
    hs.clr_overrun = 1'b1;
    tick();
    hs.clr_overrun = 1'b0;
    chk("ovr_clr2", hs.overrun, 0);
    tick(4);

    // ---- accept and new edge in the same cycle ----
    send(8'h44);
    tick(LAT);
    chk("b2b_first", hs.out_data, 8'h44);
    send(8'h55);
    tick(LAT - 1);
    hs.out_ready = 1'b1;
    tick();
    ack_exp = ~ack_exp;
    chk("b2b_ack1",    hs.ack_tgl,   ack_exp);
    chk("b2b_valid",   hs.out_valid, 1);
    chk("b2b_data",    hs.out_data,  8'h55);
    chk("b2b_overrun", hs.overrun,   0);
    tick();
    hs.out_ready = 1'b0;
    ack_exp = ~ack_exp;
    chk("b2b_ack2",   hs.ack_tgl,   ack_exp);
    chk("b2b_drop",   hs.out_valid, 0);
    tick(4);

    // ---- random stream: 16 words, sender waits on ack ----
    idx = 0; got = 0; gap = 0; cyc = 0; toggles = 0;
    waiting = 1'b0;
    ack_obs = hs.ack_tgl;
    while (got < 16 && cyc < 3000) begin
      if (waiting && (hs.ack_tgl != ack_obs || toggles > idx)) begin
        waiting = 1'b0;
        idx++;
        gap = $urandom_range(0, 3);
      end
      if (!waiting && idx < 16) begin
        if (gap == 0) begin
          send(8'(idx));
          expq.push_back(8'(idx));
          waiting = 1'b1;
        end else begin
          gap--;
        end
      end
      hs.out_ready = 1'($urandom_range(0, 1));
      acc = hs.out_valid && hs.out_ready;
      if (acc) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stream_spurious: word %0h delivered with none outstanding", hs.out_data);
        end else begin
          chk("stream_data", hs.out_data, expq.pop_front());
        end
        got++;
      end
      tick();
      if (acc) ack_exp = ~ack_exp;
      chk("stream_ack", hs.ack_tgl, ack_exp);
      if (hs.ack_tgl != ack_obs) toggles++;
      ack_obs = hs.ack_tgl;
      cyc++;
    end
    hs.out_ready = 1'b0;
    chk("stream_count",   got,         16);
    chk("stream_toggles", toggles,     16);
    chk("stream_pending", expq.size(), 0);
    chk("stream_overrun", hs.overrun,  0);
`ifdef TOGGLE_HS_RX_PARITY_EN
    chk("stream_par_err", hs.par_err,  0);
`endif
    tick(4);

    // ---- reset while VALID, then request level 1 gives one transfer ----
    send(8'h77);
    tick(LAT);
    chk("rv_valid_before", hs.out_valid, 1);
    rst = 1'b0;
    hs.req_tgl = 1'b1;
    tick();
    rst = 1'b1;
    chk("rv_valid", hs.out_valid, 0);
    chk("rv_ack",   hs.ack_tgl,   0);
    chk("rv_busy",  hs.busy,      0);
    chk("rv_data",  hs.out_data,  0);
    tick(LAT - 1);
    chk("rv_lat_early", hs.out_valid, 0);
    tick();
    chk("rv_relaunch_valid", hs.out_valid, 1);
    chk("rv_relaunch_data",  hs.out_data,  8'h77);
    hs.out_ready = 1'b1;
    tick();
    hs.out_ready = 1'b0;
    chk("rv_relaunch_ack", hs.ack_tgl, 1);
    tick(6);
    chk("rv_single_xfer", hs.out_valid, 0);
    chk("rv_single_ack",  hs.ack_tgl,   1);

`ifdef TOGGLE_HS_RX_PARITY_EN
    // ---- parity error still delivers the word ----
    hs.data_in  = 8'h01;
    hs.data_par = 1'b0;
    hs.req_tgl  = ~hs.req_tgl;
    tick(LAT);
    chk("par_err_set",  hs.par_err,   1);
    chk("par_valid",    hs.out_valid, 1);
    chk("par_data",     hs.out_data,  8'h01);
    hs.out_ready = 1'b1;
    tick();
    hs.out_ready = 1'b0;
    chk("par_ack",      hs.ack_tgl,   0);
    chk("par_err_hold", hs.par_err,   1);
    hs.clr_overrun = 1'b1;
    tick();
    hs.clr_overrun = 1'b0;
    chk("par_err_clr",  hs.par_err,   0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_hs_rx.md
Name: toggle_hs_rx

Overview:
- Receiving end of a two-phase (toggle) request/acknowledge handshake.
- A sender in another clock domain toggles req_tgl once per word and holds data_in stable until ack_tgl toggles back.
- This block synchronizes req_tgl, detects each toggle and captures data_in.
- It presents the word on a valid/ready interface, then returns the acknowledge as a toggle.

Parameters:
- DATA_W, 8, width of transferred word.
- SYNC_STAGES, 2, flops in the req_tgl synchronizer chain; legal range 2..4.

Ports:
- clk  in  1  block clock.
- rst  in  1  synchronous reset, active-low.
- req_tgl  in  1  request toggle from sender; asynchronous to clk.
- data_in  in  DATA_W  sender data; stable from req toggle until ack toggle.
- out_valid  out  1  captured word available.
- out_data  out  DATA_W  captured word.
- out_ready  in  1  consumer accepts word when high with out_valid.
- ack_tgl  out  1  acknowledge toggle to sender.
- busy  out  1  high in VALID state.
- overrun  out  1  sticky: request toggle seen while word still pending.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset: reset is rst, synchronous, active-low; clock is clk. While rst=0 at a clk rising edge, the following are cleared:
  - all sync flops = 0, req_prev = 0;
  - ack_tgl = 0, out_valid = 0, out_data = 0, overrun = 0;
  - state = IDLE.
- Reset mid-operation: a pending word is discarded and no ack is issued. Both ends are reset together by system rule. A req_tgl level of 1 after reset produces exactly one transfer.
- Edge detect: req_edge = sync_out XOR req_prev. req_prev updates to sync_out every cycle.
- Latency: req_tgl toggle to out_valid high is SYNC_STAGES+1 clk cycles.
- State IDLE:
  - On req_edge: out_data <= data_in, out_valid <= 1, go to VALID.
  - Otherwise hold.
- State VALID:
  - out_valid=1 and busy=1.
  - If out_ready=1 and no req_edge: ack_tgl <= ~ack_tgl, out_valid <= 0, go to IDLE.
  - If out_ready=1 and req_edge in the same cycle: ack_tgl toggles for the old word. The new word is captured into out_data, out_valid stays 1, state stays VALID. No overrun.
  - If out_ready=0 and req_edge: overrun <= 1. The new edge is dropped and out_data is unchanged.
- ack_tgl changes only on an accepted word, so exactly one toggle per accepted word. It is registered, with no combinational path from out_ready.
- overrun:
  - set has priority over clr_overrun in the same cycle;
  - once set, holds until clr_overrun=1 or reset.
- out_data holds its last value while out_valid=0.
- Throughput: at most one word per 2*(SYNC_STAGES+1) cycles, limited by the sender round trip.

Optional Feature:
- Macro TOGGLE_HS_RX_PARITY_EN.
- When defined:
  - adds input data_par (1) and output par_err (1, sticky);
  - at capture, if XOR(data_in, data_par) != 0, par_err <= 1;
  - the word is still delivered;
  - par_err is cleared by clr_overrun or reset; reset value 0.
- When undefined: neither port exists and there is no parity logic.

Decomposition:
- Package toggle_hs_pkg:
  - state enum {IDLE, VALID};
  - SYNC_MIN=2 and SYNC_MAX=4 constants;
  - default DATA_W constant.
- Sub-module toggle_sync: SYNC_STAGES flop chain, req_prev register and req_edge output, with synchronous active-low reset.
- The top module holds the FSM, data capture, ack toggle register and sticky flags.

Test Plan:
- Reset: assert rst=0 for 3 cycles with req_tgl=0 -> all outputs 0. Release with no toggle -> out_valid stays 0 for 20 cycles.
- Single transfer, SYNC_STAGES=2:
  - toggle req_tgl 0->1 with data_in=8'hA5 -> out_valid=1, out_data=A5 exactly 3 cycles later;
  - hold out_ready=1 -> ack_tgl goes to 1 the next cycle and out_valid drops.
- Back-pressure: word 8'h3C with out_ready=0 for 10 cycles -> out_valid, out_data=3C and busy stay high, ack_tgl unchanged. Raise out_ready -> one ack toggle.
- Overrun:
  - second req toggle while VALID and out_ready=0 -> overrun=1, out_data keeps the first word;
  - clr_overrun pulse -> overrun=0;
  - clr_overrun and a new overrun in the same cycle -> overrun=1.
- Stream of 16 words 0x00..0x0F, sender waiting on ack, random out_ready -> all 16 delivered in order, 16 ack toggles, overrun=0.
- Reset while VALID with word 8'h77 -> out_valid=0 and ack_tgl=0 on the cycle after reset. With TOGGLE_HS_RX_PARITY_EN, data 8'h01 with data_par=0 -> par_err=1 and word still delivered.
